jttrack_dwnld: RTL and testbench
================================

Name: jttrack_dwnld

Overview:
- ROM-download sequencer between the ioctl loader and the SDRAM programming port / PROM write strobes.
- Classifies each downloaded byte by region (main, snd, scr, obj, pcm, prom) and applies the per-region address swizzle.
- Queues bytes in a small FIFO and issues SDRAM writes one at a time under a we/rdy handshake.
- Sits in the game top in place of the combinational post_addr logic.

Parameters:
- SND_START, 22'h0C000, first byte of sound ROM region.
- SCR_START, 22'h0E000, first byte of scroll-tile region (swizzle A).
- OBJ_START, 22'h12000, first byte of object-tile region (swizzle B).
- PCM_START, 22'h1E000, first byte of PCM region; obj region ends here.
- PROM_START, 25'h20000, ioctl addresses at or above this go to PROMs, not SDRAM.
- FIFO_AW, 2, FIFO address width (depth = 2**FIFO_AW = 4).

Ports:
- clk  in  1  system clock (48 MHz domain)
- rst  in  1  synchronous, active-high reset
- downloading  in  1  loader active
- ioctl_wr  in  1  one-cycle byte-valid strobe
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- prog_addr  out  22  SDRAM word address
- prog_data  out  16  write data, byte duplicated {d,d}
- prog_mask  out  2  active-low byte mask
- prog_we  out  1  SDRAM write request, held until accepted
- prog_rdy  in  1  SDRAM accepted current write (one-cycle pulse)
- prom_we  out  1  one-cycle PROM write strobe
- prom_addr  out  11  ioctl_addr - PROM_START, low 11 bits
- prom_data  out  8  PROM byte
- dwnld_busy  out  1  downloading, or FIFO non-empty, or write outstanding
- dwnld_done  out  1  one-cycle pulse when download fully drained
- ovf  out  1  sticky: byte dropped because FIFO full

Behaviour:
- Reset: all outputs 0, prog_mask = 2'b11; FIFO emptied, FSM = IDLE, ovf cleared. Reset mid-write abandons the write (prog_we drops the next cycle); no retry.
- Intake: on ioctl_wr, push {ioctl_addr, ioctl_dout} the same cycle.
  - If the FIFO is full and no pop occurs that cycle, drop the byte and set ovf (ovf cleared only by rst).
  - Simultaneous push and pop on a full FIFO is accepted.
- Classification, on pop, with A = entry address:
  - A >= PROM_START: PROM.
  - SCR_START <= A < OBJ_START: scr.
  - OBJ_START <= A < PCM_START: obj.
  - Otherwise: plain.
- Swizzle to post address P (22 bits, from A[21:0]):
  - plain: P = A.
  - scr: P[0] = ~A[0].
  - obj: P[4:0] = {A[2:0], ~A[4], ~A[3]}.
- SDRAM mapping:
  - prog_addr = {1'b0, P[21:1]}.
  - prog_mask = P[0] ? 2'b01 : 2'b10.
  - prog_data = {d, d}.
- FSM:
  - IDLE: FIFO non-empty -> pop.
    - PROM entry -> PROM.
    - Otherwise load prog_* registers, assert prog_we -> WAIT.
  - WAIT: hold prog_we and all prog_* values stable until prog_rdy. On prog_rdy, prog_we=0 -> IDLE (one bubble cycle minimum between writes).
  - PROM: prom_we=1 for exactly one cycle with prom_addr/prom_data valid -> IDLE.
- Latency:
  - Empty FIFO: ioctl_wr at cycle n -> prog_we high at n+2 (push n, pop/register n+1, prog_we visible n+2).
  - PROM entries: prom_we high at n+2.
- Ordering: strictly FIFO; PROM writes never overtake pending SDRAM writes.
- dwnld_busy = downloading | FIFO non-empty | FSM != IDLE.
- dwnld_done: single pulse on the 1->0 transition of dwnld_busy. The pulse occurs after downloading has fallen, and never while a write is pending.
- prog_rdy seen outside WAIT is ignored.
- ioctl_wr while downloading=0 is still accepted.

Test Plan:
- Plain byte: addr 25'h00005, data 8'hA5, prog_rdy 3 cycles after prog_we -> prog_addr 22'h00002, prog_mask 2'b01, prog_data 16'hA5A5; prog_we high exactly until the prog_rdy cycle.
- Scroll swizzle: addr 25'h0E000, data 8'h11 -> P = 22'h0E001 -> prog_addr 22'h07000, prog_mask 2'b01.
- Object swizzle: addr 25'h12005 (A[4:0]=00101) -> P[4:0] = {101,1,1} = 5'b10111 -> prog_addr 22'h0900B, prog_mask 2'b01.
- PROM plus ordering: byte to 25'h00000, then 25'h20123 data 8'h3C while prog_rdy is withheld 10 cycles -> prom_we fires only after that prog_rdy, with prom_addr 11'h123, prom_data 8'h3C.
- Overflow: prog_rdy held low; 6 back-to-back ioctl_wr -> 1 write in WAIT, 4 queued, 6th dropped, ovf=1. Then release prog_rdy every 4 cycles -> exactly 5 writes in order; dwnld_done pulses once after downloading=0.
- Reset mid-op: assert rst while in WAIT with 2 entries queued -> next cycle prog_we=0, dwnld_busy=downloading, and no further writes after rst is released.

Source files
------------

// File: rtl/jttrack_dwnld.sv
// ROM download sequencer: classifies ioctl bytes by region, swizzles their
// addresses and drains them as single SDRAM writes (we/rdy) or PROM strobes.
module jttrack_dwnld #(
  parameter logic [21:0] SND_START  = 22'h0C000,
  parameter logic [21:0] SCR_START  = 22'h0E000,
  parameter logic [21:0] OBJ_START  = 22'h12000,
  parameter logic [21:0] PCM_START  = 22'h1E000,
  parameter logic [24:0] PROM_START = 25'h20000,
  parameter int          FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        prom_we,
  output logic [10:0] prom_addr,
  output logic [7:0]  prom_data,
  output logic        dwnld_busy,
  output logic        dwnld_done,
  output logic        ovf
);
  localparam int DEPTH = 2**FIFO_AW;

  // The classification below relies on the regions being laid out in order.
  if (!(SND_START < SCR_START && SCR_START < OBJ_START && OBJ_START < PCM_START &&
        {3'b000, PCM_START} <= PROM_START)) begin : g_bad_map
    $error("jttrack_dwnld: region start addresses are not ascending");
  end

  typedef enum logic [1:0] {IDLE, WAIT, PROM} state_t;

  state_t             state_q, state_d;
  logic [32:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [21:0]        prog_addr_q, prog_addr_d;
  logic [15:0]        prog_data_q, prog_data_d;
  logic [1:0]         prog_mask_q, prog_mask_d;
  logic               prog_we_q, prog_we_d;
  logic               prom_we_q, prom_we_d;
  logic [10:0]        prom_addr_q, prom_addr_d;
  logic [7:0]         prom_data_q, prom_data_d;
  logic               ovf_q, ovf_d;
  logic               busy_q;

  logic        fifo_empty, fifo_full, push, pop, busy;
  logic [24:0] head_addr;
  logic [7:0]  head_data;
  logic        is_prom, is_scr, is_obj;
  logic [21:0] post;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (FIFO_AW+1)'(DEPTH));
  assign head_addr  = fifo_mem[rd_ptr_q][32:8];
  assign head_data  = fifo_mem[rd_ptr_q][7:0];

  assign is_prom = head_addr >= PROM_START;
  assign is_scr  = head_addr >= {3'b000, SCR_START} && head_addr < {3'b000, OBJ_START};
  assign is_obj  = head_addr >= {3'b000, OBJ_START} && head_addr < {3'b000, PCM_START};

  always_comb begin
    post = head_addr[21:0];
    if (is_scr) begin
      post[0] = ~head_addr[0];
    end else if (is_obj) begin
      post[4:0] = {head_addr[2:0], ~head_addr[4], ~head_addr[3]};
    end
  end

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push = ioctl_wr & (~fifo_full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (ioctl_wr & fifo_full & ~pop);
    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prog_we_d   = prog_we_q;
    prom_we_d   = 1'b0;
    prom_addr_d = prom_addr_q;
    prom_data_d = prom_data_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (is_prom) begin
            state_d     = PROM;
            prom_we_d   = 1'b1;
            prom_addr_d = head_addr[10:0] - PROM_START[10:0];
            prom_data_d = head_data;
          end else begin
            state_d     = WAIT;
            prog_we_d   = 1'b1;
            prog_addr_d = {1'b0, post[21:1]};
            prog_mask_d = post[0] ? 2'b01 : 2'b10;
            prog_data_d = {head_data, head_data};
          end
        end
      end
      WAIT: begin
        if (prog_rdy) begin
          prog_we_d = 1'b0;
          state_d   = IDLE;
        end
      end
      PROM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = downloading | ~fifo_empty | (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {ioctl_addr, ioctl_dout};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= 2'b11;
      prog_we_q   <= 1'b0;
      prom_we_q   <= 1'b0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prog_we_q   <= prog_we_d;
      prom_we_q   <= prom_we_d;
      prom_addr_q <= prom_addr_d;
      prom_data_q <= prom_data_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy;
    end
  end

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_we    = prog_we_q;
  assign prom_we    = prom_we_q;
  assign prom_addr  = prom_addr_q;
  assign prom_data  = prom_data_q;
  assign ovf        = ovf_q;
  assign dwnld_busy = busy;
  assign dwnld_done = busy_q & ~busy;
endmodule

// File: tb/tb_jttrack_dwnld.sv
// Scoreboard bench for jttrack_dwnld: directed bytes push expected writes,
// a monitor pops and compares each accepted SDRAM write / PROM strobe.
module tb_jttrack_dwnld;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_rdy = 1'b0;
  logic        prom_we;
  logic [10:0] prom_addr;
  logic [7:0]  prom_data;
  logic        dwnld_busy, dwnld_done, ovf;

  int checks = 0;
  int errors = 0;
  bit rdy_en = 1'b0;
  int rdy_delay = 0;
  int rdy_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    bit          is_prom;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } exp_t;
  exp_t exp_q[$];

  jttrack_dwnld dut (
    .clk(clk), .rst(rst), .downloading(downloading), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_mask(prog_mask), .prog_we(prog_we),
    .prog_rdy(prog_rdy), .prom_we(prom_we), .prom_addr(prom_addr),
    .prom_data(prom_data), .dwnld_busy(dwnld_busy), .dwnld_done(dwnld_done),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_prog(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    exp_t e;
    e.is_prom = 1'b0; e.addr = a; e.data = {d, d}; e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic exp_prom(input logic [10:0] a, input logic [7:0] d);
    exp_t e;
    e.is_prom = 1'b1; e.addr = {11'd0, a}; e.data = {8'd0, d}; e.mask = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_remaining", exp_q.size(), 0);
  endtask

  // SDRAM acceptor: pulses prog_rdy rdy_delay cycles after prog_we is first seen
  initial begin
    forever begin
      @(negedge clk);
      if (prog_rdy) begin
        prog_rdy = 1'b0;
        rdy_cnt  = 0;
      end else if (rdy_en && prog_we) begin
        if (rdy_cnt >= rdy_delay) begin
          prog_rdy = 1'b1;
          rdy_cnt  = 0;
        end else begin
          rdy_cnt++;
        end
      end else begin
        rdy_cnt = 0;
      end
    end
  end

  // Monitor: compares every accepted write against the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (dwnld_done) done_cnt++;
    if (!rst && prog_we && prog_rdy) begin
      $display("sdram write addr=%h data=%h mask=%b", prog_addr, prog_data, prog_mask);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL prog_unexpected: got write addr 0x%0h, expected none", prog_addr);
      end else begin
        e = exp_q.pop_front();
        if (e.is_prom) begin
          errors++;
          $display("FAIL prog_order: got sdram write addr 0x%0h, expected prom write", prog_addr);
        end else begin
          chk("prog_addr", prog_addr, e.addr);
          chk("prog_data", prog_data, e.data);
          chk("prog_mask", prog_mask, e.mask);
        end
      end
    end
    if (!rst && prom_we) begin
      $display("prom write addr=%h data=%h", prom_addr, prom_data);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL prom_unexpected: got prom addr 0x%0h, expected none", prom_addr);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_prom) begin
          errors++;
          $display("FAIL prom_order: got prom addr 0x%0h, expected sdram addr 0x%0h", prom_addr, e.addr);
        end else begin
          chk("prom_addr", prom_addr, e.addr[10:0]);
          chk("prom_data", prom_data, e.data[7:0]);
        end
      end
    end
  end

  // Region table: ioctl address, data, expected prog_addr, expected prog_mask
  logic [24:0] rt_a [9] = '{25'h0E000, 25'h0E003, 25'h12005, 25'h1201A, 25'h1DFFF,
                            25'h1E000, 25'h0DFFF, 25'h1FFFF, 25'h11FFF};
  logic [7:0]  rt_d [9] = '{8'h11, 8'h22, 8'h42, 8'h99, 8'h5C, 8'h66, 8'h33, 8'h44, 8'h55};
  logic [21:0] rt_p [9] = '{22'h07000, 22'h07001, 22'h0900B, 22'h09004, 22'h0EFFE,
                            22'h0F000, 22'h06FFF, 22'h0FFFF, 22'h08FFF};
  logic [1:0]  rt_m [9] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10};

  // Overflow burst: first five bytes are expected, the sixth must be dropped
  logic [21:0] ov_p [5] = '{22'h00080, 22'h00080, 22'h00081, 22'h00081, 22'h00082};
  logic [1:0]  ov_m [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    int base;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_prog_we", prog_we, 0);
    chk("rst_prog_mask", prog_mask, 2'b11);
    chk("rst_prog_addr", prog_addr, 0);
    chk("rst_prom_we", prom_we, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", dwnld_busy, 0);
    chk("rst_done", dwnld_done, 0);
    rst = 1'b0;
    downloading = 1'b1;
    @(negedge clk);

    // Plain byte with latency and handshake timing
    rdy_delay = 3; rdy_en = 1'b1;
    exp_prog(22'h00002, 8'hA5, 2'b01);
    write_byte(25'h00005, 8'hA5);
    chk("lat_n1_prog_we", prog_we, 0);
    @(negedge clk);
    chk("lat_n2_prog_we", prog_we, 1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("hold_prog_we", prog_we, 1);
    end
    @(negedge clk);
    chk("release_prog_we", prog_we, 0);
    wait_drain();

    // Region classification and swizzles
    rdy_delay = 1;
    for (int i = 0; i < 9; i++) begin
      exp_prog(rt_p[i], rt_d[i], rt_m[i]);
      write_byte(rt_a[i], rt_d[i]);
    end
    wait_drain();

    // PROM latency on an empty FIFO, single-cycle strobe
    exp_prom(11'h7FF, 8'h5A);
    write_byte(25'h207FF, 8'h5A);
    chk("prom_lat_n1", prom_we, 0);
    @(negedge clk);
    chk("prom_lat_n2", prom_we, 1);
    @(negedge clk);
    chk("prom_one_cycle", prom_we, 0);
    wait_drain();

    // PROM must wait behind a slow SDRAM write
    rdy_delay = 10;
    exp_prog(22'h00000, 8'h77, 2'b10);
    exp_prom(11'h123, 8'h3C);
    write_byte(25'h00000, 8'h77);
    write_byte(25'h20123, 8'h3C);
    wait_drain();

    // Overflow: six back-to-back bytes while SDRAM is stalled
    rdy_en = 1'b0;
    for (int i = 0; i < 5; i++) exp_prog(ov_p[i], 8'h10 + 8'(i), ov_m[i]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ioctl_wr = 1'b1;
      ioctl_addr = 25'h100 + 25'(i);
      ioctl_dout = 8'h10 + 8'(i);
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("ovf_set", ovf, 1);
    chk("ovf_busy", dwnld_busy, 1);
    base = done_cnt;
    downloading = 1'b0;
    rdy_delay = 3; rdy_en = 1'b1;
    wait_drain();
    repeat (6) @(negedge clk);
    chk("done_pulses", done_cnt - base, 1);
    chk("drained_busy", dwnld_busy, 0);
    chk("ovf_sticky", ovf, 1);

    // Reset while a write is outstanding with two bytes queued
    rdy_en = 1'b0;
    downloading = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ioctl_wr = 1'b1;
      ioctl_addr = 25'h200 + 25'(i);
      ioctl_dout = 8'hC0 + 8'(i);
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("pre_rst_prog_we", prog_we, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_prog_we", prog_we, 0);
    chk("rst_mid_busy", dwnld_busy, downloading);
    chk("rst_mid_ovf", ovf, 0);
    chk("rst_mid_mask", prog_mask, 2'b11);
    rst = 1'b0;
    rdy_delay = 0; rdy_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_prog_we", prog_we, 0);
    chk("post_rst_prom_we", prom_we, 0);
    downloading = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", dwnld_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
